// File: rtl/trig_counter_snapshot.sv
// Free-running and trigger-driven up/down counters with a coherent two-cycle
// snapshot path and registered event pulses for a TriggerOut endpoint.
module trig_counter_snapshot #(
  parameter int WIDTH     = 32,
  parameter int SATURATE  = 0,
  parameter int AUTO_LOG2 = 0,
  parameter int LED_MSB   = 30,
  // With WIDTH=16 there is no upper half; the hi ports collapse to one zero bit
  localparam int HI_W     = (WIDTH > 16) ? WIDTH - 16 : 1
) (
  input  logic            clk1,
  input  logic            reset_n,
  input  logic [3:0]      trig,
  input  logic            run_en,
  output logic [15:0]     snap0_lo,
  output logic [HI_W-1:0] snap0_hi,
  output logic [15:0]     snap1_lo,
  output logic [HI_W-1:0] snap1_hi,
  output logic [7:0]      snap_seq,
  output logic [7:0]      led_cnt,
  output logic [2:0]      evt,
  output logic            busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
  } cnt_pair_t;

  logic [WIDTH-1:0] count0, count1, count1_nxt;
  logic [WIDTH-1:0] snap0, snap1;
  cnt_pair_t        hold;
  state_t           state;
  logic             t_clear, t_up, t_down, t_snap;
  logic             up_only, dn_only, c1_max, c1_min;
  logic             auto_tick;
  logic [2:0]       evt_nxt;

  assign t_clear = trig[0];
  assign t_up    = trig[1];
  assign t_down  = trig[2];
  assign t_snap  = trig[3];
  assign up_only = t_up & ~t_down & ~t_clear;
  assign dn_only = t_down & ~t_up & ~t_clear;
  assign c1_max  = (count1 == '1);
  assign c1_min  = (count1 == '0);

  // Limit events fire on every attempt to step past a limit, wrapping or not
  assign evt_nxt = {dn_only & c1_min, up_only & c1_max, run_en & (count0 == '1)};

  always_comb begin
    count1_nxt = count1;
    if (t_clear)                          count1_nxt = '0;
    else if (up_only && !(SATURATE != 0 && c1_max)) count1_nxt = count1 + ONE;
    else if (dn_only && !(SATURATE != 0 && c1_min)) count1_nxt = count1 - ONE;
  end

  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      count0 <= '0;
      count1 <= '0;
      evt    <= '0;
    end else begin
      if (run_en) count0 <= count0 + ONE;
      count1 <= count1_nxt;
      evt    <= evt_nxt;
    end
  end

  generate
    if (AUTO_LOG2 > 0) begin : g_auto
      logic [AUTO_LOG2-1:0] timer;
      always_ff @(posedge clk1) begin
        if (!reset_n) timer <= '0;
        else          timer <= timer + AUTO_LOG2'(1);
      end
      // Request on the edge where the timer rolls over to zero
      assign auto_tick = &timer;
    end else begin : g_no_auto
      assign auto_tick = 1'b0;
    end
  endgenerate

  // Counts are parked in hold at the request edge and published one cycle later
  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      hold     <= '0;
      snap0    <= '0;
      snap1    <= '0;
      snap_seq <= '0;
    end else begin
      case (state)
        IDLE: if (t_snap || auto_tick) begin
          state   <= CAPTURE;
          busy    <= 1'b1;
          hold.c0 <= count0;
          hold.c1 <= count1;
        end
        CAPTURE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          snap0    <= hold.c0;
          snap1    <= hold.c1;
          snap_seq <= snap_seq + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign snap0_lo = snap0[15:0];
  assign snap1_lo = snap1[15:0];

  generate
    if (WIDTH > 16) begin : g_hi
      assign snap0_hi = snap0[WIDTH-1:16];
      assign snap1_hi = snap1[WIDTH-1:16];
    end else begin : g_no_hi
      assign snap0_hi = '0;
      assign snap1_hi = '0;
    end
  endgenerate

  assign led_cnt = count0[LED_MSB -: 8];

endmodule

// File: tb/tb_trig_counter_snapshot.sv
// Bench for trig_counter_snapshot: three builds (32-bit wrap, 16-bit saturate,
// 16-bit auto-snapshot) share one stimulus; snapshots are scoreboarded.
module tb_trig_counter_snapshot;

  logic       clk1, reset_n, run_en;
  logic [3:0] trig;

  logic [15:0] s0l_a, s0h_a, s1l_a, s1h_a;
  logic [7:0]  seq_a, led_a;
  logic [2:0]  evt_a;
  logic        busy_a;
  logic [15:0] s0l_b, s1l_b, s0l_c, s1l_c;
  logic [0:0]  s0h_b, s1h_b, s0h_c, s1h_c;
  logic [7:0]  seq_b, led_b, seq_c, led_c;
  logic [2:0]  evt_b, evt_c;
  logic        busy_b, busy_c;

  trig_counter_snapshot #(.WIDTH(32), .SATURATE(0), .AUTO_LOG2(0), .LED_MSB(30)) u_a (
    .clk1(clk1), .reset_n(reset_n), .trig(trig), .run_en(run_en),
    .snap0_lo(s0l_a), .snap0_hi(s0h_a), .snap1_lo(s1l_a), .snap1_hi(s1h_a),
    .snap_seq(seq_a), .led_cnt(led_a), .evt(evt_a), .busy(busy_a));

  trig_counter_snapshot #(.WIDTH(16), .SATURATE(1), .AUTO_LOG2(0), .LED_MSB(15)) u_b (
    .clk1(clk1), .reset_n(reset_n), .trig(trig), .run_en(run_en),
    .snap0_lo(s0l_b), .snap0_hi(s0h_b), .snap1_lo(s1l_b), .snap1_hi(s1h_b),
    .snap_seq(seq_b), .led_cnt(led_b), .evt(evt_b), .busy(busy_b));

  trig_counter_snapshot #(.WIDTH(16), .SATURATE(0), .AUTO_LOG2(4), .LED_MSB(15)) u_c (
    .clk1(clk1), .reset_n(reset_n), .trig(trig), .run_en(run_en),
    .snap0_lo(s0l_c), .snap0_hi(s0h_c), .snap1_lo(s1l_c), .snap1_hi(s1h_c),
    .snap_seq(seq_c), .led_cnt(led_c), .evt(evt_c), .busy(busy_c));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [7:0]  seq;
  } snap_t;

  typedef struct {
    logic [3:0] trig;
    bit         push;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       busy;
  } vec_t;

  snap_t qa[$], qb[$];
  vec_t  tbl[$];
  int    checks = 0, errors = 0, wraps_b = 0;
  bit    cnt_wraps = 0;
  logic [7:0] last_a = '0, last_b = '0, eseq_a = '0, eseq_b = '0;

  // Reference counters for builds A and B
  logic [31:0] m0a, m1a;
  logic [15:0] m0b, m1b;

  function automatic logic [31:0] nxt_a(input logic [31:0] v, input logic [3:0] t);
    if (t[0])              return 32'd0;
    else if (t[1] && t[2]) return v;
    else if (t[1])         return v + 32'd1;
    else if (t[2])         return v - 32'd1;
    return v;
  endfunction

  function automatic logic [15:0] nxt_b(input logic [15:0] v, input logic [3:0] t);
    if (t[0])              return 16'd0;
    else if (t[1] && t[2]) return v;
    else if (t[1])         return (v == 16'hFFFF) ? v : v + 16'd1;
    else if (t[2])         return (v == 16'd0) ? v : v - 16'd1;
    return v;
  endfunction

  always @(posedge clk1) begin
    if (!reset_n) begin
      m0a <= '0; m1a <= '0; m0b <= '0; m1b <= '0;
    end else begin
      if (run_en) begin
        m0a <= m0a + 32'd1;
        m0b <= m0b + 16'd1;
      end
      m1a <= nxt_a(m1a, trig);
      m1b <= nxt_b(m1b, trig);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called after every falling edge: pops the scoreboard whenever a build publishes a snapshot
  task automatic mon();
    snap_t e;
    if (seq_a !== last_a) begin
      if (seq_a != 8'd0) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL snap_a_unexpected: seq 0x%0h, expected no capture", seq_a);
        end else begin
          e = qa.pop_front();
          chk("snap_a_cnt0", {32'd0, s0h_a, s0l_a}, {32'd0, e.s0});
          chk("snap_a_cnt1", {32'd0, s1h_a, s1l_a}, {32'd0, e.s1});
          chk("snap_a_seq",  {56'd0, seq_a}, {56'd0, e.seq});
        end
      end
      last_a = seq_a;
    end
    if (seq_b !== last_b) begin
      if (seq_b != 8'd0) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL snap_b_unexpected: seq 0x%0h, expected no capture", seq_b);
        end else begin
          e = qb.pop_front();
          chk("snap_b_cnt0", {47'd0, s0h_b, s0l_b}, {32'd0, e.s0});
          chk("snap_b_cnt1", {47'd0, s1h_b, s1l_b}, {32'd0, e.s1});
          chk("snap_b_seq",  {56'd0, seq_b}, {56'd0, e.seq});
        end
      end
      last_b = seq_b;
    end
    if (cnt_wraps && evt_b[0]) wraps_b++;
  endtask

  task automatic tick();
    @(negedge clk1);
    mon();
  endtask

  task automatic push_exp();
    eseq_a++;
    qa.push_back('{m0a, m1a, eseq_a});
    eseq_b++;
    qb.push_back('{{16'd0, m0b}, {16'd0, m1b}, eseq_b});
  endtask

  task automatic snap_pulse(input bit push);
    trig = 4'b1000;
    if (push) push_exp();
    tick();
    trig = 4'b0000;
  endtask

  task automatic drained(input string nm);
    chk({nm, "_qa_empty"}, 64'(qa.size()), 64'd0);
    chk({nm, "_qb_empty"}, 64'(qb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    trig    = 4'b0000;
    tick();
    tick();
    qa.delete(); qb.delete();
    eseq_a = '0; eseq_b = '0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a_snap"}, {s0h_a, s0l_a, s1h_a, s1l_a}, 64'd0);
    chk({nm, "_a_misc"}, {44'd0, seq_a, led_a, evt_a, busy_a}, 64'd0);
    chk({nm, "_b_snap"}, {30'd0, s0h_b, s0l_b, s1h_b, s1l_b}, 64'd0);
    chk({nm, "_b_misc"}, {44'd0, seq_b, led_b, evt_b, busy_b}, 64'd0);
    chk({nm, "_c_snap"}, {30'd0, s0h_c, s0l_c, s1h_c, s1l_c}, 64'd0);
    chk({nm, "_c_misc"}, {44'd0, seq_c, led_c, evt_c, busy_c}, 64'd0);
  endtask

  initial begin
    // {trig, push, evt A, evt B, busy} applied one cycle each with run_en=0
    tbl.push_back('{4'b0100, 1'b0, 3'b100, 3'b100, 1'b0});
    tbl.push_back('{4'b0001, 1'b0, 3'b000, 3'b000, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{4'b0010, 1'b0, 3'b000, 3'b000, 1'b0});
    for (int i = 0; i < 2; i++) tbl.push_back('{4'b0100, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0110, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b1000, 1'b1, 3'b000, 3'b000, 1'b1});
    tbl.push_back('{4'b0000, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0001, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0001, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0101, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0100, 1'b0, 3'b100, 3'b100, 1'b0});
    tbl.push_back('{4'b0010, 1'b0, 3'b010, 3'b000, 1'b0});
    tbl.push_back('{4'b1000, 1'b1, 3'b000, 3'b000, 1'b1});
    tbl.push_back('{4'b1000, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b1110, 1'b1, 3'b000, 3'b000, 1'b1});
    tbl.push_back('{4'b0000, 1'b0, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{4'b1010, 1'b1, 3'b000, 3'b000, 1'b1});
    tbl.push_back('{4'b0000, 1'b0, 3'b000, 3'b000, 1'b0});

    reset_n = 1'b0; run_en = 1'b0; trig = 4'b0000;

    // Reset values, then 100 counting cycles and a request
    do_reset();
    chk_zero("reset");
    reset_n = 1'b1; run_en = 1'b1;
    repeat (100) tick();
    snap_pulse(1'b1);
    chk("p1_busy_a", {63'd0, busy_a}, 64'd1);
    chk("p1_busy_b", {63'd0, busy_b}, 64'd1);
    tick();
    chk("p1_busy_low", {62'd0, busy_a, busy_b}, 64'd0);
    chk("p1_snap0_a", {48'd0, s0l_a}, 64'd100);
    chk("p1_snap1_a", {32'd0, s1h_a, s1l_a}, 64'd0);
    chk("p1_seq_a",   {56'd0, seq_a}, 64'd1);

    // Trigger table
    run_en = 1'b0;
    foreach (tbl[i]) begin
      trig = tbl[i].trig;
      if (tbl[i].push) push_exp();
      tick();
      chk($sformatf("tbl%0d_evt_a", i), {61'd0, evt_a}, {61'd0, tbl[i].ea});
      chk($sformatf("tbl%0d_evt_b", i), {61'd0, evt_b}, {61'd0, tbl[i].eb});
      chk($sformatf("tbl%0d_busy", i), {62'd0, busy_a, busy_b}, {62'd0, tbl[i].busy, tbl[i].busy});
    end
    trig = 4'b0000;
    tick();
    tick();
    drained("tbl");

    // count0 wrap on the 16-bit build, snapshot taken at 0xFFFF
    do_reset();
    reset_n = 1'b1; run_en = 1'b1; cnt_wraps = 1'b1;
    repeat (65535) tick();
    chk("wrap_led_b", {56'd0, led_b}, 64'hFF);
    snap_pulse(1'b1);
    chk("wrap_evt0_b", {63'd0, evt_b[0]}, 64'd1);
    chk("wrap_busy_b", {63'd0, busy_b}, 64'd1);
    tick();
    chk("wrap_evt0_clr", {63'd0, evt_b[0]}, 64'd0);
    chk("wrap_snap0_b", {48'd0, s0l_b}, 64'hFFFF);
    repeat (20) tick();
    chk("wrap_snap0_stable", {48'd0, s0l_b}, 64'hFFFF);
    chk("wrap_seq_stable", {56'd0, seq_b}, 64'd1);
    chk("wrap_evt0_once", 64'(wraps_b), 64'd1);
    cnt_wraps = 1'b0;
    drained("wrap");

    // Auto snapshots every 16 cycles, a coincident and a dropped request
    do_reset();
    reset_n = 1'b1; run_en = 1'b1;
    repeat (16) tick();
    chk("auto1_busy_c", {63'd0, busy_c}, 64'd1);
    tick();
    chk("auto1_seq_c", {56'd0, seq_c}, 64'd1);
    chk("auto1_snap0_c", {48'd0, s0l_c}, 64'd15);
    repeat (14) tick();
    snap_pulse(1'b1);
    chk("auto2_busy_c", {63'd0, busy_c}, 64'd1);
    snap_pulse(1'b0);
    chk("auto2_seq_c", {56'd0, seq_c}, 64'd2);
    chk("auto2_snap0_c", {48'd0, s0l_c}, 64'd31);
    tick();
    chk("auto2_drop_seq_c", {56'd0, seq_c}, 64'd2);
    chk("auto2_drop_busy_c", {63'd0, busy_c}, 64'd0);
    repeat (14) tick();
    chk("auto3_busy_c", {63'd0, busy_c}, 64'd1);
    tick();
    chk("auto3_seq_c", {56'd0, seq_c}, 64'd3);
    chk("auto3_snap0_c", {48'd0, s0l_c}, 64'd47);
    tick();
    drained("auto");

    // Reset landing on the capture cycle together with countup
    do_reset();
    reset_n = 1'b1; run_en = 1'b1;
    trig = 4'b0010;
    repeat (3) tick();
    trig = 4'b0000;
    snap_pulse(1'b0);
    reset_n = 1'b0; trig = 4'b0010;
    tick();
    trig = 4'b0000; run_en = 1'b0;
    chk_zero("midcap");
    reset_n = 1'b1;
    tick();
    snap_pulse(1'b1);
    tick();
    chk("midcap_snap1_a", {32'd0, s1h_a, s1l_a}, 64'd0);
    chk("midcap_snap0_a", {32'd0, s0h_a, s0l_a}, 64'd0);
    chk("midcap_seq_a", {56'd0, seq_a}, 64'd1);
    tick();
    drained("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
